// File: rtl/risc_pkg.sv
// risc_pkg: instruction encodings and field positions shared across the RISC core.
package risc_pkg;
    typedef enum logic [1:0] {TYPE_R = 2'b00, TYPE_J = 2'b01, TYPE_I = 2'b10, TYPE_S = 2'b11} instr_type_e;
    typedef enum logic [1:0] {PC_DFT = 2'b00, PC_BTA = 2'b01, PC_JMP = 2'b10, PC_RA = 2'b11} pc_src_e;
    typedef enum logic [4:0] {
        FC_NOP = 5'd0, FC_JAL = 5'd1, FC_ADD = 5'd2, FC_SUB = 5'd3,
        FC_LW = 5'd4, FC_SW = 5'd5, FC_BEQ = 5'd6
    } func_code_e;
    typedef enum logic [1:0] {IDLE, REQ, CAPT} fetch_state_e;
    localparam int FC_HI = 31, FC_LO = 27;
    localparam int RS1_HI = 26, RS1_LO = 22;
    localparam int RD_HI = 21, RD_LO = 17;
    localparam int RS2_HI = 16, RS2_LO = 12;
    localparam int IMM_HI = 16, IMM_LO = 3;
    localparam int JOFF_HI = 26, JOFF_LO = 3;
    localparam int TYPE_HI = 2, TYPE_LO = 1;
    localparam int STOP_BIT = 0;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: control-unit request, instruction memory and decode bundle of the fetch stage.
interface instruction_fetch_unit_if #(parameter int ADDR_W = 32);
    logic              en_instruction_fetch;
    logic [1:0]        sig_pc_src;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd_en;
    logic [31:0]       imem_rdata;
    logic [31:0]       instruction;
    logic [1:0]        InstructionType;
    logic [4:0]        FunctionCode;
    logic              StopBit;
    logic [4:0]        rs1;
    logic [4:0]        rd;
    logic [4:0]        rs2;
    logic [13:0]       imm14;
    logic [ADDR_W-1:0] pc;
    logic              instr_valid;
    logic              busy;
    logic              ras_overflow;
    logic              ras_underflow;
    modport slave (
        input  en_instruction_fetch, sig_pc_src, imem_rdata,
        output imem_addr, imem_rd_en, instruction, InstructionType, FunctionCode, StopBit,
               rs1, rd, rs2, imm14, pc, instr_valid, busy, ras_overflow, ras_underflow
    );
    modport master (
        output en_instruction_fetch, sig_pc_src, imem_rdata,
        input  imem_addr, imem_rd_en, instruction, InstructionType, FunctionCode, StopBit,
               rs1, rd, rs2, imm14, pc, instr_valid, busy, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry.
module return_address_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW:0]      count;
    logic             full;
    assign full      = count == (PW+1)'(DEPTH);
    assign empty     = count == '0;
    assign top       = mem[wp - PW'(1)];
    assign overflow  = push && full;
    assign underflow = pop && empty;
    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            mem[wp] <= push_data;
            wp      <= wp + PW'(1);
            count   <= full ? count : count + (PW+1)'(1);
        end else if (pop && !empty) begin
            wp    <= wp - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: three-cycle fetch FSM with next-PC selection, IR decode and JAL return stack.
module instruction_fetch_unit
    import risc_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clock,
    input logic reset,
    instruction_fetch_unit_if.slave bus
);
    fetch_state_e      state, state_nx;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc_q, pc_nx, ras_top;
    logic              first_fetch, instr_valid_q, ovf_q, unf_q;
    logic              accept, push, pop, ras_empty, ras_ovf, ras_unf;
    return_address_stack #(.DEPTH(RAS_DEPTH), .WIDTH(ADDR_W)) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + ADDR_W'(1)),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );
    always_comb begin
        state_nx = IDLE;
        accept   = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        pc_nx    = RESET_PC;
        accept   = (state == IDLE) && bus.en_instruction_fetch;
        state_nx = (state == IDLE) ? (accept ? REQ : IDLE) : (state == REQ) ? CAPT : IDLE;
        pop      = accept && !first_fetch && (bus.sig_pc_src == PC_RA);
        push     = (state == CAPT) && (bus.imem_rdata[TYPE_HI:TYPE_LO] == TYPE_J)
                   && (bus.imem_rdata[FC_HI:FC_LO] == FC_JAL);
        // an empty stack returns to RESET_PC rather than a stale entry
        pc_nx    = first_fetch                  ? RESET_PC :
                   (bus.sig_pc_src == PC_DFT)   ? pc_q + ADDR_W'(1) :
                   (bus.sig_pc_src == PC_BTA)   ? pc_q + ADDR_W'($signed(ir[IMM_HI:IMM_LO])) :
                   (bus.sig_pc_src == PC_JMP)   ? pc_q + ADDR_W'($signed(ir[JOFF_HI:JOFF_LO])) :
                   ras_empty                    ? RESET_PC : ras_top;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pc_q          <= RESET_PC;
            ir            <= '0;
            first_fetch   <= 1'b1;
            instr_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            state         <= state_nx;
            instr_valid_q <= state == CAPT;
            ovf_q         <= ovf_q | ras_ovf;
            unf_q         <= unf_q | ras_unf;
            if (accept) begin
                pc_q        <= pc_nx;
                first_fetch <= 1'b0;
            end
            if (state == CAPT) ir <= bus.imem_rdata;
        end
    end
    assign bus.imem_addr       = pc_q;
    assign bus.imem_rd_en      = state == REQ;
    assign bus.instruction     = ir;
    assign bus.InstructionType = ir[TYPE_HI:TYPE_LO];
    assign bus.FunctionCode    = ir[FC_HI:FC_LO];
    assign bus.StopBit         = ir[STOP_BIT];
    assign bus.rs1             = ir[RS1_HI:RS1_LO];
    assign bus.rd              = ir[RD_HI:RD_LO];
    assign bus.rs2             = ir[RS2_HI:RS2_LO];
    assign bus.imm14           = ir[IMM_HI:IMM_LO];
    assign bus.pc              = pc_q;
    assign bus.instr_valid     = instr_valid_q;
    assign bus.busy            = state != IDLE;
    assign bus.ras_overflow    = ovf_q;
    assign bus.ras_underflow   = unf_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch sequences checked against a queue-based model of the fetch stage.
module tb_instruction_fetch_unit;
    localparam int AW = 32;
    localparam logic [AW-1:0] RPC = '0;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    instruction_fetch_unit_if #(.ADDR_W(AW)) bus ();
    instruction_fetch_unit #(.ADDR_W(AW), .RAS_DEPTH(4), .RESET_PC(RPC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clock = ~clock;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_pc, m_ir;
    logic [31:0] ras_q [$];
    bit m_first, m_ovf, m_unf;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        if (mem.exists(a)) return mem[a];
        w = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
        if (w[9:7] == 3'd0) w = {5'd1, w[26:3], 2'b01, w[0]};
        return w;
    endfunction

    function automatic logic [31:0] jmp_word(input logic [23:0] off);
        return {5'd2, off, 2'b10, 1'b0};
    endfunction

    function automatic logic [31:0] imm_word(input logic [13:0] imm);
        return {5'd2, 5'd3, 5'd4, imm, 2'b10, 1'b1};
    endfunction

    function automatic logic [31:0] jal_word();
        return {5'd1, 24'd0, 2'b01, 1'b0};
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_ir = '0; m_first = 1; m_ovf = 0; m_unf = 0;
        ras_q.delete();
    endtask

    // one accepted request: next address from the architectural rules, then the captured word
    task automatic model_step(input logic [1:0] src);
        logic [31:0] np;
        if (m_first) np = RPC;
        else if (src == 2'd0) np = m_pc + 1;
        else if (src == 2'd1) np = m_pc + {{18{m_ir[16]}}, m_ir[16:3]};
        else if (src == 2'd2) np = m_pc + {{8{m_ir[26]}}, m_ir[26:3]};
        else if (ras_q.size() == 0) begin np = RPC; m_unf = 1; end
        else np = ras_q.pop_back();
        m_first = 0;
        m_pc = np;
        m_ir = word_at(np);
        if (m_ir[2:1] == 2'b01 && m_ir[31:27] == 5'd1) begin
            ras_q.push_back(np + 1);
            if (ras_q.size() > 4) begin
                void'(ras_q.pop_front());
                m_ovf = 1;
            end
        end
    endtask

    always @(posedge clock) if (bus.imem_rd_en) bus.imem_rdata <= word_at(bus.imem_addr);

    task automatic do_reset();
        @(negedge clock);
        reset = 1; bus.en_instruction_fetch = 0; bus.sig_pc_src = 2'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        model_reset();
    endtask

    task automatic fetch(input logic [1:0] src, input string tag);
        @(negedge clock);
        bus.en_instruction_fetch = 1; bus.sig_pc_src = src;
        model_step(src);
        @(negedge clock);
        bus.en_instruction_fetch = 0;
        total++;
        if ({bus.imem_addr, bus.imem_rd_en, bus.busy} !== {m_pc, 2'b11}) begin
            bad++;
            $display("FAIL %s req: addr/rd_en/busy got %h/%b/%b want %h/1/1", tag, bus.imem_addr, bus.imem_rd_en, bus.busy, m_pc);
        end
        @(negedge clock);
        total++;
        if ({bus.instr_valid, bus.imem_rd_en, bus.busy} !== 3'b001) begin
            bad++;
            $display("FAIL %s capt: valid/rd_en/busy got %b/%b/%b want 0/0/1", tag, bus.instr_valid, bus.imem_rd_en, bus.busy);
        end
        @(negedge clock);
        total++;
        if ({bus.instr_valid, bus.busy, bus.instruction, bus.pc} !== {2'b10, m_ir, m_pc}) begin
            bad++;
            $display("FAIL %s present: valid/busy/ir/pc got %b/%b/%h/%h want 1/0/%h/%h", tag, bus.instr_valid, bus.busy, bus.instruction, bus.pc, m_ir, m_pc);
        end
        total++;
        if ({bus.InstructionType, bus.FunctionCode, bus.StopBit, bus.rs1, bus.rd, bus.rs2, bus.imm14} !==
            {m_ir[2:1], m_ir[31:27], m_ir[0], m_ir[26:22], m_ir[21:17], m_ir[16:12], m_ir[16:3]}) begin
            bad++;
            $display("FAIL %s decode: type/fc/stop got %h/%h/%b want %h/%h/%b", tag, bus.InstructionType, bus.FunctionCode, bus.StopBit, m_ir[2:1], m_ir[31:27], m_ir[0]);
        end
        total++;
        if ({bus.ras_overflow, bus.ras_underflow} !== {m_ovf, m_unf}) begin
            bad++;
            $display("FAIL %s flags: ovf/unf got %b/%b want %b/%b", tag, bus.ras_overflow, bus.ras_underflow, m_ovf, m_unf);
        end
    endtask

    task automatic test_reset();
        mem.delete();
        do_reset();
        repeat (2) begin
            @(negedge clock);
            total++;
            if ({bus.instruction, bus.pc, bus.imem_addr, bus.instr_valid, bus.imem_rd_en, bus.busy, bus.ras_overflow, bus.ras_underflow} !== {32'h0, RPC, RPC, 5'b0}) begin
                bad++;
                $display("FAIL reset: ir/pc/valid/rd/busy got %h/%h/%b/%b/%b want 0/%h/0/0/0", bus.instruction, bus.pc, bus.instr_valid, bus.imem_rd_en, bus.busy, RPC);
            end
            total++;
            if ({bus.InstructionType, bus.FunctionCode, bus.StopBit, bus.rs1, bus.rd, bus.rs2, bus.imm14} !== 37'h0) begin
                bad++;
                $display("FAIL reset decode: fc/rs1/imm got %h/%h/%h want 0", bus.FunctionCode, bus.rs1, bus.imm14);
            end
        end
    endtask

    task automatic test_first_fetch();
        mem.delete();
        mem[32'h0] = imm_word(14'h0123);
        do_reset();
        fetch(2'd1, "first_bta");
    endtask

    task automatic test_bta();
        mem.delete();
        mem[32'h0] = jmp_word(24'h10);
        mem[32'h10] = imm_word(14'h3FFE);
        do_reset();
        fetch(2'd0, "bta_first");
        fetch(2'd2, "bta_jmp");
        fetch(2'd1, "bta_neg");
        total++;
        if (bus.pc !== 32'h0E) begin
            bad++;
            $display("FAIL bta_target: pc got %h want 0000000e", bus.pc);
        end
    endtask

    task automatic test_jmp_wrap();
        mem.delete();
        mem[32'h0] = jmp_word(24'hFFFFFF);
        do_reset();
        fetch(2'd3, "wrap_first");
        fetch(2'd2, "wrap_jmp");
        total++;
        if (bus.pc !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL jmp_wrap: pc got %h want ffffffff", bus.pc);
        end
    endtask

    task automatic test_jal();
        mem.delete();
        mem[32'h0] = jmp_word(24'h20);
        mem[32'h20] = jal_word();
        mem[32'h21] = imm_word(14'h0);
        do_reset();
        fetch(2'd0, "jal_first");
        fetch(2'd2, "jal_jmp");
        fetch(2'd3, "jal_ret");
        total++;
        if (bus.pc !== 32'h21) begin
            bad++;
            $display("FAIL jal_ret_addr: pc got %h want 00000021", bus.pc);
        end
        fetch(2'd3, "jal_empty");
        total++;
        if ({bus.pc, bus.ras_underflow} !== {RPC, 1'b1}) begin
            bad++;
            $display("FAIL jal_empty_pop: pc/unf got %h/%b want %h/1", bus.pc, bus.ras_underflow, RPC);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret;
        mem.delete();
        mem[32'h0] = jmp_word(24'h100);
        for (int i = 0; i < 5; i++) mem[32'h100 + i] = jal_word();
        do_reset();
        fetch(2'd0, "ovf_first");
        fetch(2'd2, "ovf_jal0");
        for (int i = 1; i < 5; i++) fetch(2'd0, "ovf_jal");
        total++;
        if ({bus.ras_overflow, bus.ras_underflow} !== 2'b10) begin
            bad++;
            $display("FAIL ovf_flag: ovf/unf got %b/%b want 1/0", bus.ras_overflow, bus.ras_underflow);
        end
        for (int i = 0; i < 6; i++) mem[32'h100 + i] = imm_word(14'h5);
        exp_ret = 32'h105;
        for (int i = 0; i < 4; i++) begin
            fetch(2'd3, "ovf_pop");
            total++;
            if (bus.pc !== exp_ret) begin
                bad++;
                $display("FAIL ovf_pop_addr: pc got %h want %h", bus.pc, exp_ret);
            end
            exp_ret = exp_ret - 1;
        end
        fetch(2'd3, "ovf_under");
        total++;
        if ({bus.pc, bus.ras_underflow, bus.ras_overflow} !== {RPC, 2'b11}) begin
            bad++;
            $display("FAIL ovf_underflow: pc/unf/ovf got %h/%b/%b want %h/1/1", bus.pc, bus.ras_underflow, bus.ras_overflow, RPC);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int ph;
        mem.delete();
        do_reset();
        @(negedge clock);
        bus.en_instruction_fetch = 1; bus.sig_pc_src = 2'd0;
        model_step(2'd0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            ph = (c - 1) % 3;
            if (c == 9) bus.en_instruction_fetch = 0;
            if (bus.instr_valid) pulses++;
            total++;
            if ({bus.busy, bus.imem_rd_en, bus.instr_valid} !== {ph != 2, ph == 0, ph == 2}) begin
                bad++;
                $display("FAIL b2b_cycle%0d: busy/rd/valid got %b/%b/%b want %b/%b/%b", c, bus.busy, bus.imem_rd_en, bus.instr_valid, ph != 2, ph == 0, ph == 2);
            end
            if (ph == 0 && bus.imem_addr !== m_pc) begin
                total++; bad++;
                $display("FAIL b2b_addr: got %h want %h", bus.imem_addr, m_pc);
            end
            if (ph == 2) begin
                total++;
                if (bus.instruction !== m_ir) begin
                    bad++;
                    $display("FAIL b2b_ir: got %h want %h", bus.instruction, m_ir);
                end
                if (c < 9) model_step(2'd0);
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL b2b_count: valid pulses got %0d want 3", pulses);
        end
    endtask

    task automatic test_reset_in_capt();
        mem.delete();
        mem[32'h0] = jal_word();
        mem[32'h1] = imm_word(14'h7);
        do_reset();
        fetch(2'd0, "rst_warm");
        @(negedge clock);
        bus.en_instruction_fetch = 1; bus.sig_pc_src = 2'd0;
        @(negedge clock);
        bus.en_instruction_fetch = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        model_reset();
        total++;
        if ({bus.instruction, bus.instr_valid, bus.busy, bus.pc} !== {32'h0, 2'b00, RPC}) begin
            bad++;
            $display("FAIL rst_capt: ir/valid/busy/pc got %h/%b/%b/%h want 0/0/0/%h", bus.instruction, bus.instr_valid, bus.busy, bus.pc, RPC);
        end
        @(negedge clock);
        total++;
        if (bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_capt_valid: got %b want 0", bus.instr_valid);
        end
        fetch(2'd2, "rst_refetch");
        fetch(2'd3, "rst_ret");
        fetch(2'd3, "rst_empty");
    endtask

    task automatic test_random();
        mem.delete();
        do_reset();
        for (int i = 0; i < 30; i++) fetch(2'($urandom_range(0, 3)), "rand");
    endtask

    initial begin
        bus.en_instruction_fetch = 0;
        bus.sig_pc_src = 2'd0;
        model_reset();
        test_reset();
        test_first_fetch();
        test_bta();
        test_jmp_wrap();
        test_jal();
        test_overflow();
        test_back_to_back();
        test_reset_in_capt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
